// File: rtl/riscv_pkg.sv
// Shared RV32I shift encodings: internal shift-type codes and the funct3/funct7
// patterns that select them.
package riscv_pkg;

  typedef enum logic [1:0] {
    SHIFT_SRL = 2'b00,
    SHIFT_SLL = 2'b01,
    SHIFT_SRA = 2'b10
  } shift_type_e;

  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SRA  = 7'b0100000;

endpackage

// File: rtl/shift_decode.sv
// Combinational decode of an RV32I shift into shift type, shift amount and an
// illegal flag. Illegal encodings report SHIFT_SRL so type 11 never escapes.
module shift_decode
  import riscv_pkg::*;
#(
  parameter int SHAMT_W = 5
) (
  input  logic               is_imm,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [11:0]        imm,
  input  logic [SHAMT_W-1:0] rs2_lo,
  output logic [1:0]         stype,
  output logic [SHAMT_W-1:0] shamt,
  output logic               illegal
);

  logic [6:0]  sel_f7_s;
  shift_type_e stype_s;

  // Decode funct3 and the selected funct7 field into type/shamt/illegal.
  always_comb begin
    sel_f7_s = is_imm ? imm[11:5] : funct7;
    shamt    = is_imm ? imm[SHAMT_W-1:0] : rs2_lo;
    stype_s  = SHIFT_SRL;
    illegal  = 1'b1;
    case (funct3)
      F3_SLL: begin
        if (sel_f7_s == F7_BASE) begin
          stype_s = SHIFT_SLL;
          illegal = 1'b0;
        end else begin
          stype_s = SHIFT_SRL;
          illegal = 1'b1;
        end
      end
      F3_SR: begin
        if (sel_f7_s == F7_SRA) begin
          stype_s = SHIFT_SRA;
          illegal = 1'b0;
        end else if (sel_f7_s == F7_BASE) begin
          stype_s = SHIFT_SRL;
          illegal = 1'b0;
        end else begin
          stype_s = SHIFT_SRL;
          illegal = 1'b1;
        end
      end
      default: begin
        stype_s = SHIFT_SRL;
        illegal = 1'b1;
      end
    endcase
  end

  assign stype = stype_s;

endmodule

// File: rtl/shift_issue_stage.sv
// Decode->execute issue stage for RV32I shifts: decodes on accept and holds
// ops in a 2-entry skid buffer whose head entry drives the shifter directly.
module shift_issue_stage
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_is_imm,
  input  logic [2:0]         in_funct3,
  input  logic [6:0]         in_funct7,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [XLEN-1:0]    in_rs2,
  input  logic [11:0]        in_imm,
  input  logic [TAG_W-1:0]   in_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_a,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic [1:0]         out_type,
  output logic [TAG_W-1:0]   out_rd,
  output logic               out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]    a;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         stype;
    logic [TAG_W-1:0]   rd;
    logic               illegal;
  } entry_t;

  entry_t             ent0_r;
  entry_t             ent1_r;
  entry_t             dec_entry_s;
  logic               ent0_vld_r;
  logic               ent1_vld_r;
  logic               in_fire_s;
  logic               out_fire_s;
  logic               ent0_free_s;
  logic [1:0]         dec_type_s;
  logic [SHAMT_W-1:0] dec_shamt_s;
  logic               dec_illegal_s;
  logic               unused_rs2_s;

  // Only the low bits of rs2 carry a shift amount on RV32.
  assign unused_rs2_s = ^in_rs2[XLEN-1:SHAMT_W];

  shift_decode #(
    .SHAMT_W(SHAMT_W)
  ) u_decode (
    .is_imm (in_is_imm),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .rs2_lo (in_rs2[SHAMT_W-1:0]),
    .stype  (dec_type_s),
    .shamt  (dec_shamt_s),
    .illegal(dec_illegal_s)
  );

  assign dec_entry_s = {in_rs1, dec_shamt_s, dec_type_s, in_rd, dec_illegal_s};

  // in_ready depends only on the skid entry, so no path from out_ready.
  assign in_ready    = ~ent1_vld_r;
  assign in_fire_s   = in_valid & ~ent1_vld_r;
  assign out_fire_s  = ent0_vld_r & out_ready;
  assign ent0_free_s = ~ent0_vld_r | out_fire_s;

  // Skid buffer: refill the head from the skid entry first, then from the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_r     <= '0;
      ent1_r     <= '0;
      ent0_vld_r <= 1'b0;
      ent1_vld_r <= 1'b0;
    end else if (flush) begin
      ent0_vld_r <= 1'b0;
      ent1_vld_r <= 1'b0;
    end else if (ent0_free_s) begin
      if (ent1_vld_r) begin
        ent0_r     <= ent1_r;
        ent0_vld_r <= 1'b1;
        ent1_vld_r <= 1'b0;
      end else if (in_fire_s) begin
        ent0_r     <= dec_entry_s;
        ent0_vld_r <= 1'b1;
      end else begin
        ent0_vld_r <= 1'b0;
      end
    end else if (in_fire_s) begin
      ent1_r     <= dec_entry_s;
      ent1_vld_r <= 1'b1;
    end
  end

  assign out_valid   = ent0_vld_r;
  assign out_a       = ent0_r.a;
  assign out_shamt   = ent0_r.shamt;
  assign out_type    = ent0_r.stype;
  assign out_rd      = ent0_r.rd;
  assign out_illegal = ent0_r.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Self-checking bench for shift_issue_stage: decode vector table, hand-written
// backpressure/flush/reset sequences and a randomized queue-model stream.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_imm;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [11:0] in_imm;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [4:0]  out_shamt;
  logic [1:0]  out_type;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_imm(in_is_imm),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
    .out_shamt(out_shamt), .out_type(out_type), .out_rd(out_rd),
    .out_illegal(out_illegal)
  );

  wire [44:0] out_bits = {out_a, out_shamt, out_type, out_rd, out_illegal};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference decode written straight from the legal-encoding list.
  function automatic logic [44:0] ref_op(input logic is_imm, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [31:0] rs1,
                                         input logic [31:0] rs2, input logic [11:0] imm,
                                         input logic [4:0] rd);
    logic [6:0] sel;
    logic [4:0] sh;
    logic [1:0] ty;
    logic       ill;
    sel = is_imm ? imm[11:5] : f7;
    sh  = is_imm ? imm[4:0] : rs2[4:0];
    ty  = 2'b00;
    ill = 1'b1;
    if (f3 == 3'd1 && sel == 7'h00) begin ty = 2'b01; ill = 1'b0; end
    else if (f3 == 3'd5 && sel == 7'h00) begin ty = 2'b00; ill = 1'b0; end
    else if (f3 == 3'd5 && sel == 7'h20) begin ty = 2'b10; ill = 1'b0; end
    return {rs1, sh, ty, rd, ill};
  endfunction

  task automatic set_op(input logic is_imm, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [11:0] imm, input logic [4:0] rd);
    in_is_imm = is_imm; in_funct3 = f3; in_funct7 = f7;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_rd = rd;
  endtask

  typedef struct {
    logic        is_imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [11:0] imm;
    logic [4:0]  rd;
    logic [1:0]  ety;
    logic [4:0]  esh;
    logic        eill;
  } vec_t;

  vec_t      vecs[10];
  logic [44:0] q[$];

  initial begin
    int sent;
    int popped;
    int cyc;
    logic do_pop;
    logic do_push;
    logic [44:0] exp;

    // expected type / shamt / illegal are hand-derived constants
    vecs[0] = '{1'b1, 3'b101, 7'h00, 32'h8000_0010, 32'h0, 12'h402, 5'd7,  2'b10, 5'd2,  1'b0}; // SRAI
    vecs[1] = '{1'b1, 3'b001, 7'h00, 32'h0000_0001, 32'h0, 12'h01f, 5'd1,  2'b01, 5'd31, 1'b0}; // SLLI 31
    vecs[2] = '{1'b1, 3'b101, 7'h7f, 32'hdead_beef, 32'h0, 12'h005, 5'd2,  2'b00, 5'd5,  1'b0}; // SRLI
    vecs[3] = '{1'b0, 3'b001, 7'h00, 32'h1234_5678, 32'hffff_ffe3, 12'hfff, 5'd3, 2'b01, 5'd3, 1'b0}; // SLL
    vecs[4] = '{1'b0, 3'b101, 7'h20, 32'hf000_0000, 32'h0000_0040, 12'h000, 5'd4, 2'b10, 5'd0, 1'b0}; // SRA
    vecs[5] = '{1'b0, 3'b101, 7'h00, 32'h0f0f_0f0f, 32'h0000_001c, 12'h400, 5'd31, 2'b00, 5'd28, 1'b0}; // SRL
    vecs[6] = '{1'b1, 3'b001, 7'h00, 32'h5555_aaaa, 32'h0, 12'h020, 5'd8,  2'b00, 5'd0,  1'b1}; // SLLI imm[5]
    vecs[7] = '{1'b0, 3'b000, 7'h00, 32'h0000_0003, 32'h0000_0002, 12'h0, 5'd9, 2'b00, 5'd2, 1'b1}; // funct3 000
    vecs[8] = '{1'b1, 3'b101, 7'h00, 32'h0000_0004, 32'h0, 12'h601, 5'd10, 2'b00, 5'd1,  1'b1}; // SRAI bad f7
    vecs[9] = '{1'b0, 3'b001, 7'h20, 32'h0000_0005, 32'h0000_0001, 12'h0, 5'd11, 2'b00, 5'd1, 1'b1}; // SLL f7=0x20

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_op(1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 12'd0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_out_valid", 64'(out_valid), 64'd0);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_out_bits", 64'(out_bits), 64'd0);

    // decode table, one op per cycle with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_op(vecs[i].is_imm, vecs[i].f3, vecs[i].f7, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].rd);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_type", i), 64'(out_type), 64'(vecs[i].ety));
      chk($sformatf("vec%0d_shamt", i), 64'(out_shamt), 64'(vecs[i].esh));
      chk($sformatf("vec%0d_illegal", i), 64'(out_illegal), 64'(vecs[i].eill));
      chk($sformatf("vec%0d_a", i), 64'(out_a), 64'(vecs[i].rs1));
      chk($sformatf("vec%0d_rd", i), 64'(out_rd), 64'(vecs[i].rd));
    end
    @(negedge clk);
    chk("vec_drain_valid", 64'(out_valid), 64'd0);

    // backpressure: SLL then SRL, held, then drained in order
    out_ready = 1'b0;
    set_op(1'b0, 3'b001, 7'h00, 32'h0000_1234, 32'h0000_0023, 12'h0, 5'd3);
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_first_valid", 64'(out_valid), 64'd1);
    chk("bp_first_shamt", 64'(out_shamt), 64'd3);
    chk("bp_first_type", 64'(out_type), 64'd1);
    chk("bp_ready_one", 64'(in_ready), 64'd1);
    set_op(1'b0, 3'b101, 7'h00, 32'h0000_5678, 32'h0000_0004, 12'h0, 5'd4);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_ready_full", 64'(in_ready), 64'd0);
    chk("bp_hold_rd", 64'(out_rd), 64'd3);
    @(negedge clk);
    chk("bp_hold_bits", 64'(out_bits), 64'(ref_op(1'b0, 3'b001, 7'h00, 32'h0000_1234, 32'h23, 12'h0, 5'd3)));
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_second_bits", 64'(out_bits), 64'(ref_op(1'b0, 3'b101, 7'h00, 32'h0000_5678, 32'h4, 12'h0, 5'd4)));
    chk("bp_second_valid", 64'(out_valid), 64'd1);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("bp_empty", 64'(out_valid), 64'd0);

    // flush with two ops buffered and an input offered
    out_ready = 1'b0;
    set_op(1'b1, 3'b001, 7'h00, 32'h1, 32'h0, 12'h001, 5'd12);
    in_valid = 1'b1;
    @(negedge clk);
    set_op(1'b1, 3'b001, 7'h00, 32'h2, 32'h0, 12'h002, 5'd13);
    @(negedge clk);
    set_op(1'b1, 3'b001, 7'h00, 32'h3, 32'h0, 12'h003, 5'd14);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl2_out_valid", 64'(out_valid), 64'd0);
    chk("fl2_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("fl2_still_empty", 64'(out_valid), 64'd0);

    // flush with one op held while a new input is accepted: both lost
    set_op(1'b1, 3'b001, 7'h00, 32'h4, 32'h0, 12'h004, 5'd15);
    in_valid = 1'b1;
    @(negedge clk);
    set_op(1'b1, 3'b001, 7'h00, 32'h5, 32'h0, 12'h005, 5'd16);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl1_out_valid", 64'(out_valid), 64'd0);
    chk("fl1_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("fl1_input_lost", 64'(out_valid), 64'd0);

    // asynchronous reset mid-cycle with both entries full
    set_op(1'b1, 3'b101, 7'h00, 32'hffff_ffff, 32'h0, 12'h407, 5'd17);
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_bits", 64'(out_bits), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_after_release", 64'(out_valid), 64'd0);

    // random legal stream against a queue model
    sent = 0; popped = 0; cyc = 0;
    q.delete();
    while ((sent < 100 || q.size() > 0) && cyc < 3000) begin
      cyc++;
      chk("rnd_out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("rnd_in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (q.size() > 0) chk("rnd_payload", 64'(out_bits), 64'(q[0]));
      in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 1) == 1;
      begin
        int k;
        logic [31:0] r;
        logic [6:0] sel;
        k   = $urandom_range(0, 5);
        r   = $urandom;
        sel = (k % 3 == 2) ? 7'h20 : 7'h00;
        set_op(k >= 3, (k % 3 == 0) ? 3'b001 : 3'b101,
               (k >= 3) ? r[31:25] : sel, $urandom, $urandom,
               (k >= 3) ? {sel, r[4:0]} : r[11:0], r[20:16]);
      end
      exp = ref_op(in_is_imm, in_funct3, in_funct7, in_rs1, in_rs2, in_imm, in_rd);
      do_pop  = (q.size() > 0) && out_ready;
      do_push = in_valid && (q.size() < 2);
      if (do_pop) begin
        void'(q.pop_front());
        popped++;
      end
      if (do_push) begin
        q.push_back(exp);
        sent++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("rnd_no_timeout", 64'(cyc < 3000), 64'd1);
    chk("rnd_popped_all", 64'(popped), 64'd100);
    chk("rnd_final_empty", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
